// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU) using one restoring
// radix-2 step per clock, with single-cycle handling of divide-by-zero and signed overflow.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [1:0]  DIV_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        ready,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken when valid_in is high in IDLE with flush low;
  // ready drops in that same cycle and stays low until the result strobe
  // (valid_out, one cycle, in DONE), where ready is high again.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dvsr_q;
  logic        q_neg;
  logic        r_neg;
  logic        rem_sel;

  logic        accept;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div_zero;
  logic        sgn_ovf;
  logic [31:0] special_res;
  logic [32:0] trial;
  logic [31:0] shifted_rem;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    accept      = (state == IDLE) && valid_in && !flush;
    a_neg       = A[31] && !DIV_op[0];
    b_neg       = B[31] && !DIV_op[0];
    a_abs       = a_neg ? (~A + 32'd1) : A;
    b_abs       = b_neg ? (~B + 32'd1) : B;
    div_zero    = (B == 32'd0);
    sgn_ovf     = !DIV_op[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero)
      special_res = DIV_op[1] ? A : 32'hFFFF_FFFF;
    else if (sgn_ovf)
      special_res = DIV_op[1] ? 32'd0 : 32'h8000_0000;
  end

  // Restoring step: the shifted partial remainder needs 33 bits for the trial
  // subtraction; a borrow (bit 32 set) means the divisor did not fit.
  always_comb begin
    shifted_rem = {rem_q[30:0], quot_q[31]};
    trial       = {rem_q, quot_q[31]} - {1'b0, dvsr_q};
    q_fix       = q_neg ? (~quot_q + 32'd1) : quot_q;
    r_fix       = r_neg ? (~rem_q + 32'd1) : rem_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      dvsr_q    <= 32'd0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rem_sel   <= 1'b0;
      valid_out <= 1'b0;
      result    <= 32'd0;
    end else begin
      valid_out <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (div_zero || sgn_ovf) begin
                result    <= special_res;
                valid_out <= 1'b1;
                state     <= DONE;
              end else begin
                quot_q  <= a_abs;
                dvsr_q  <= b_abs;
                rem_q   <= 32'd0;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
                rem_sel <= DIV_op[1];
                cnt     <= 5'd31;
                state   <= CALC;
              end
            end
          end
          CALC: begin
            if (!trial[32]) begin
              rem_q  <= trial[31:0];
              quot_q <= {quot_q[30:0], 1'b1};
            end else begin
              rem_q  <= shifted_rem;
              quot_q <= {quot_q[30:0], 1'b0};
            end
            if (cnt == 5'd0)
              state <= CORR;
            else
              cnt <= cnt - 5'd1;
          end
          CORR: begin
            result    <= rem_sel ? r_fix : q_fix;
            valid_out <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ready     = ((state == IDLE) && !accept) || (state == DONE);
    state_dbg = state;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous reset, active-low.
REQ-004 Port: valid_in  input  1  start request; operands and op sampled when accepted.
REQ-005 Port: DIV_op  input  2  bit0=1 unsigned, bit1=1 remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU).
REQ-006 Port: A  input  32  dividend.
REQ-007 Port: B  input  32  divisor.
REQ-008 Port: flush  input  1  synchronous abort of any operation in progress.
REQ-009 Port: ready  output  1  high = unit can accept or has finished; low = pipeline must stall.
REQ-010 Port: valid_out  output  1  one-cycle result strobe.
REQ-011 Port: result  output  32  quotient or remainder per DIV_op.

Function
REQ-012 States SHALL be IDLE, CALC, CORR, DONE.
REQ-013 valid_in SHALL be accepted only in IDLE with flush low; valid_in in any other state SHALL be ignored.
REQ-014 ready SHALL be high in IDLE and DONE and low in CALC and CORR.
REQ-015 ready SHALL also be driven low combinationally in the IDLE cycle where valid_in is accepted, so the stall is immediate.
REQ-016 Special case B==0: accept -> DONE next edge; result = 0xFFFFFFFF for DIV/DIVU, A for REM/REMU.
REQ-017 Special case signed (DIV_op[0]=0), A==0x80000000, B==0xFFFFFFFF: accept -> DONE next edge; result = 0x80000000 for DIV, 0 for REM.
REQ-018 Otherwise, on accept, the block SHALL latch |A| and |B| (absolute value only when signed), the quotient sign sA^sB, the remainder sign sA, and DIV_op. It SHALL clear the partial remainder and load the 5-bit iteration counter with 31, then enter CALC.
REQ-019 CALC SHALL perform one restoring radix-2 step per edge, 32 steps total: shift the {rem,quot} pair, trial-subtract the divisor on 33 bits, and keep the result if non-negative with quot LSB=1. After the step with counter==0 it SHALL go to CORR.
REQ-020 CORR SHALL apply the sign correction (two's complement negate when the sign is set), select quotient or remainder, register result, then go to DONE.
REQ-021 Latency for the normal path: valid_out SHALL be high in the 34th cycle after the accepting edge. Latency for the special cases: valid_out SHALL be high in the cycle after the accepting edge.
REQ-022 valid_out SHALL be high exactly in DONE, for one cycle; DONE -> IDLE unconditionally.
REQ-023 result SHALL hold its value from DONE until the next write in CORR or a special-case accept.
REQ-024 flush SHALL force state to IDLE at the next edge from any state, with no valid_out produced for the aborted operation.
REQ-025 If flush is high in DONE, valid_out in that cycle SHALL be unaffected.
REQ-026 If flush and valid_in are both high in IDLE, flush SHALL win and the operation SHALL not be accepted.
REQ-027 Operand inputs SHALL be ignored after acceptance; changes during CALC/CORR SHALL not affect result.

Reset
REQ-028 While reset is low: state=IDLE, ready=1, valid_out=0, result=0x00000000, counter=0, internal operand/remainder registers=0.
REQ-029 Assertion mid-operation SHALL abort it immediately (asynchronous), with no valid_out after release.
REQ-030 The first valid_in SHALL be accepted on the first rising edge after reset is released.

Verification
REQ-031 DIVU A=100 B=7 -> ready low from the accept cycle, valid_out in cycle 34, result=14; repeat with REMU -> result=2.
REQ-032 DIV A=0xFFFFFFF9 (-7) B=2 -> result=0xFFFFFFFD; REM on the same operands -> result=0xFFFFFFFF; DIV -7/-2 -> 3.
REQ-033 DIVU A=5 B=0 -> valid_out next cycle, result=0xFFFFFFFF; REM A=5 B=0 -> result=5.
REQ-034 DIV A=0x80000000 B=0xFFFFFFFF -> result=0x80000000 after 1 cycle; REM on the same operands -> result=0.
REQ-035 Flush at the 10th CALC cycle -> IDLE next edge, ready=1, no valid_out in the following 40 cycles. A new DIVU 9/3 accepted afterwards -> result=3.
REQ-036 reset driven low at the 20th CALC cycle -> ready=1, valid_out=0, result=0 without a clock edge. After release, REMU 0xFFFFFFFF/16 -> result=15.
